serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller that time-shares a single full-adder cell between all bit positions of a WIDTH-bit addition.
- The full-adder cell is two half_adder instances plus an OR gate.
- Sequences the cell one bit per clock, LSB first, and holds the running carry in a flop.
- Sits above the gate-level adder primitives as the first sequential arithmetic unit. It trades latency for a single adder cell.

---
 rtl/serial_adder_ctrl.sv | 145 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell (two half adders
// plus an OR) sequenced LSB first, one bit per clock, carry held in a flop.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  // Single-bit sum and carry.
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_bit_c, b_bit_c;
  logic               hs1_c, hc1_c, bit_c, hc2_c, carry_new_c;

  // Select the operand bits addressed by the current bit index.
  always_comb begin
    a_bit_c = 1'b0;
    b_bit_c = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (idx_q == CNT_W'(i)) begin
        a_bit_c = opa_q[i];
        b_bit_c = opb_q[i];
      end
    end
  end

  // The shared full-adder cell.
  half_adder u_ha0 (.a_i(a_bit_c), .b_i(b_bit_c), .s_o(hs1_c), .c_o(hc1_c));
  half_adder u_ha1 (.a_i(hs1_c),   .b_i(carry_q), .s_o(bit_c), .c_o(hc2_c));
  assign carry_new_c = hc1_c | hc2_c;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          if (idx_q == CNT_W'(i)) begin
            sum_d[i] = bit_c;
          end
        end
        carry_d = carry_new_c;
        idx_d   = idx_q + CNT_W'(1);
        if (idx_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = carry_new_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=4 and WIDTH=1.

module tb_serial_adder_ctrl;

  localparam int unsigned W4 = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic          start4, cin4, busy4, done4, cout4;
  logic [W4-1:0] a4, b4, sum4;

  logic          start1, cin1, busy1, done1, cout1;
  logic [0:0]    a1, b1, sum1;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // One full WIDTH=4 operation with junk on the inputs while it runs.
  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                      input string tag);
    int lat;
    logic [4:0] expv;
    expv   = 5'(av) + 5'(bv) + 5'(cv);
    start4 = 1'b1; a4 = av; b4 = bv; cin4 = cv;
    tick();
    lat = 0;
    while (done4 !== 1'b1 && lat < 3 * int'(W4)) begin
      start4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      tick();
      lat++;
    end
    start4 = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'(W4));
    check({tag, "_res"}, 64'({cout4, sum4}), 64'(expv));
    tick();
    check({tag, "_idle"}, 64'({busy4, done4, cout4, sum4}), 64'({2'b00, expv}));
  endtask

  initial begin
    int ndone;
    int lat;
    int done_cyc [3];
    logic [3:0] ra, rb;
    logic [3:0] bb_a [3];
    logic [3:0] bb_b [3];
    logic [4:0] expv;

    rst_n  = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) tick();
    check("reset_w4", 64'({busy4, done4, cout4, sum4}), 64'(0));
    check("reset_w1", 64'({busy1, done1, cout1, sum1}), 64'(0));
    rst_n = 1'b1;
    tick();

    // 3 + 5 with cycle-by-cycle busy/done timing.
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd5; cin4 = 1'b0;
    tick();
    start4 = 1'b0;
    check("t1_e0", 64'({busy4, done4, cout4, sum4}), 64'({2'b10, 5'd0}));
    for (int j = 1; j <= 3; j++) begin
      tick();
      check("t1_run", 64'({busy4, done4}), 64'(2'b10));
    end
    tick();
    check("t1_done", 64'({busy4, done4, cout4, sum4}), 64'({2'b11, 5'd8}));
    tick();
    check("t1_idle", 64'({busy4, done4, cout4, sum4}), 64'({2'b00, 5'd8}));
    tick();
    check("t1_hold", 64'({busy4, done4, cout4, sum4}), 64'({2'b00, 5'd8}));

    run4(4'd15, 4'd1,  1'b0, "d15_1");
    run4(4'd15, 4'd15, 1'b1, "d15_15_1");
    run4(4'd0,  4'd0,  1'b1, "d0_0_1");

    // start held high throughout, operands churned during RUN.
    start4 = 1'b1; a4 = 4'd6; b4 = 4'd9; cin4 = 1'b0;
    tick();
    ndone = 0;
    for (int j = 1; j <= 4; j++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      tick();
      if (done4 === 1'b1) begin
        ndone++;
        check("hold_res", 64'({cout4, sum4}), 64'(5'd15));
      end
    end
    tick();
    if (done4 === 1'b1) ndone++;
    check("hold_one_done", 64'(ndone), 64'(1));
    check("hold_no_e5_accept", 64'(busy4), 64'(0));
    ra = 4'($urandom); rb = 4'($urandom);
    a4 = ra; b4 = rb; cin4 = 1'b0;
    tick();
    start4 = 1'b0;
    check("hold_e6_accept", 64'(busy4), 64'(1));
    lat = 0;
    while (done4 !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check("hold_second_res", 64'({done4, cout4, sum4}), 64'({1'b1, 5'(5'(ra) + 5'(rb))}));
    tick();

    // Asynchronous reset in the middle of 7 + 7.
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd7; cin4 = 1'b0;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 64'({busy4, done4, cout4, sum4}), 64'(0));
    ndone = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (done4 !== 1'b0) ndone++;
    end
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (done4 !== 1'b0) ndone++;
    end
    check("rst_no_done", 64'(ndone), 64'(0));
    run4(4'd2, 4'd3, 1'b0, "post_rst");

    // Back-to-back: restart in the first IDLE cycle after each done.
    bb_a[0] = 4'd1;  bb_b[0] = 4'd1;
    bb_a[1] = 4'd8;  bb_b[1] = 4'd8;
    bb_a[2] = 4'd12; bb_b[2] = 4'd5;
    for (int k = 0; k < 3; k++) begin
      start4 = 1'b1; a4 = bb_a[k]; b4 = bb_b[k]; cin4 = 1'b0;
      tick();
      start4 = 1'b0;
      lat = 0;
      while (done4 !== 1'b1 && lat < 12) begin
        tick();
        lat++;
      end
      done_cyc[k] = cyc;
      expv = 5'(bb_a[k]) + 5'(bb_b[k]);
      check("b2b_res", 64'({done4, cout4, sum4}), 64'({1'b1, expv}));
      if (k > 0) check("b2b_spacing", 64'(done_cyc[k] - done_cyc[k-1]), 64'(6));
      tick();
    end

    // Exhaustive a, b, cin at WIDTH=4.
    for (int v = 0; v < 512; v++) begin
      run4(4'(v), 4'(v >> 4), 1'(v >> 8), "exh");
    end

    // Random operands with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      run4(4'($urandom), 4'($urandom), 1'($urandom), "rnd");
    end

    // WIDTH=1: exhaustive with 3-cycle turnaround.
    for (int v = 0; v < 8; v++) begin
      expv   = 5'(v & 1) + 5'((v >> 1) & 1) + 5'((v >> 2) & 1);
      start1 = 1'b1; a1 = 1'(v); b1 = 1'(v >> 1); cin1 = 1'(v >> 2);
      tick();
      start1 = 1'b0;
      check("w1_run", 64'({busy1, done1}), 64'(2'b10));
      tick();
      check("w1_done", 64'({busy1, done1, cout1, sum1}), 64'({2'b11, expv[1:0]}));
      tick();
      check("w1_idle", 64'({busy1, done1, cout1, sum1}), 64'({2'b00, expv[1:0]}));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
